// File: rtl/cbc_axi_wr_master.sv
// cbc_axi_wr_master: drains the CBC output stream into memory as AXI4 INCR bursts.
// Ports: wmst_* control/status, axis_slv_* 128-bit stream in, m_axi_* AW/W/B master.
module cbc_axi_wr_master #(
  parameter int MAX_BURST_LEN   = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic          aclk,
  input  logic          areset_n,
  input  logic          wmst_req,
  input  logic [63:0]   wmst_xfer_addr,
  input  logic [63:0]   wmst_xfer_size,
  output logic          wmst_busy,
  output logic          wmst_done,
  output logic          wmst_error,
  input  logic          axis_slv_tvalid,
  output logic          axis_slv_tready,
  input  logic [127:0]  axis_slv_tdata,
  output logic          m_axi_awvalid,
  input  logic          m_axi_awready,
  output logic [63:0]   m_axi_awaddr,
  output logic [7:0]    m_axi_awlen,
  output logic [2:0]    m_axi_awsize,
  output logic [1:0]    m_axi_awburst,
  output logic          m_axi_wvalid,
  input  logic          m_axi_wready,
  output logic [127:0]  m_axi_wdata,
  output logic [15:0]   m_axi_wstrb,
  output logic          m_axi_wlast,
  input  logic          m_axi_bvalid,
  output logic          m_axi_bready,
  input  logic [1:0]    m_axi_bresp
);

  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int PW =
    (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [OW-1:0] MOS = OW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTSTANDING - 1);
  localparam logic [8:0]    MBL = 9'(MAX_BURST_LEN);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [63:0]     addr_q;
  logic [59:0]     aw_rem_q;
  logic [OW-1:0]   out_q, out_d;
  logic [OW-1:0]   fcnt_q, fcnt_d;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [7:0]      fifo_mem [MAX_OUTSTANDING];
  logic [7:0]      beat_q;
  logic            err_q;

  logic            start, run, aw_pend;
  logic            fifo_ne, fifo_full;
  logic [8:0]      page, cap, len;
  logic [7:0]      head_len;
  logic            aw_hs, w_hs, last_hs, b_hs;
  logic            run_end;
  logic            unused_size_lsb;

  assign unused_size_lsb = ^wmst_xfer_size[3:0];

  assign start     = (state_q == IDLE) && wmst_req;
  assign run       = (state_q == RUN);
  assign aw_pend   = run && (aw_rem_q != '0);
  assign fifo_ne   = (fcnt_q != '0);
  assign fifo_full = (fcnt_q == MOS);
  assign head_len  = fifo_mem[rd_ptr_q];

  // Burst length: remaining beats, capped by the burst limit
  // and by the beats left before the next 4KB page.
  assign page = 9'd256 - {1'b0, addr_q[11:4]};
  assign cap  = (aw_rem_q < 60'(MAX_BURST_LEN)) ?
                aw_rem_q[8:0] : MBL;
  assign len  = (cap < page) ? cap : page;

  assign aw_hs   = m_axi_awvalid && m_axi_awready;
  assign w_hs    = m_axi_wvalid && m_axi_wready;
  assign last_hs = w_hs && m_axi_wlast;
  assign b_hs    = m_axi_bvalid && m_axi_bready;

  always_comb begin
    out_d = out_q;
    if (aw_hs && !b_hs)
      out_d = out_q + OW'(1);
    else if (!aw_hs && b_hs && out_q != '0)
      out_d = out_q - OW'(1);
  end

  always_comb begin
    fcnt_d = fcnt_q;
    if (aw_hs && !last_hs)
      fcnt_d = fcnt_q + OW'(1);
    else if (!aw_hs && last_hs)
      fcnt_d = fcnt_q - OW'(1);
  end

  assign run_end = (aw_rem_q == '0) && (fcnt_d == '0)
                && (out_d == '0);

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (wmst_req)
              state_d = (wmst_xfer_size[63:4] == '0) ?
                        DONE : RUN;
      RUN:  if (run_end) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wmst_busy       = (state_q != IDLE);
    wmst_done       = (state_q == DONE);
    wmst_error      = (state_q == DONE) && err_q;
    m_axi_awvalid   = aw_pend && (out_q < MOS) && !fifo_full;
    m_axi_awaddr    = aw_pend ? addr_q : '0;
    m_axi_awlen     = aw_pend ? 8'(len - 9'd1) : '0;
    m_axi_awsize    = 3'b100;
    m_axi_awburst   = 2'b01;
    // W is a pure pass-through gated by an issued burst.
    m_axi_wvalid    = axis_slv_tvalid && fifo_ne;
    axis_slv_tready = m_axi_wready && fifo_ne;
    m_axi_wdata     = fifo_ne ? axis_slv_tdata : '0;
    m_axi_wstrb     = 16'hFFFF;
    m_axi_wlast     = fifo_ne && (beat_q == head_len);
    m_axi_bready    = run;
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      addr_q   <= '0;
      aw_rem_q <= '0;
      out_q    <= '0;
      fcnt_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      beat_q   <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++)
        fifo_mem[i] <= '0;
    end else if (start) begin
      addr_q   <= wmst_xfer_addr;
      aw_rem_q <= wmst_xfer_size[63:4];
      out_q    <= '0;
      fcnt_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      beat_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      out_q  <= out_d;
      fcnt_q <= fcnt_d;
      if (aw_hs) begin
        addr_q   <= addr_q + {51'b0, len, 4'b0};
        aw_rem_q <= aw_rem_q - 60'(len);
        fifo_mem[wr_ptr_q] <= 8'(len - 9'd1);
        wr_ptr_q <= (wr_ptr_q == LAST_PTR) ?
                    '0 : wr_ptr_q + PW'(1);
      end
      if (w_hs) begin
        if (m_axi_wlast) begin
          beat_q   <= '0;
          rd_ptr_q <= (rd_ptr_q == LAST_PTR) ?
                      '0 : rd_ptr_q + PW'(1);
        end else begin
          beat_q <= beat_q + 8'd1;
        end
      end
      if (b_hs && m_axi_bresp != 2'b00)
        err_q <= 1'b1;
    end
  end

  b_underflow: assert property (@(posedge aclk)
    disable iff (!areset_n) !(b_hs && out_q == '0));

endmodule

// File: doc/cbc_axi_wr_master.md
Name: cbc_axi_wr_master

Overview:
- Consumer end of the CBC engine's write-master control interface and output stream.
- On a one-cycle request it takes a byte address and byte count, then pulls 128-bit words from the AXI-stream slave port.
- It writes those words to global memory as AXI4 INCR bursts, and raises a done/error indication once every write response has returned.
- Sits between the CBC engine output FIFO and the kernel's AXI4 memory-mapped master port.

Parameters:
- MAX_BURST_LEN, 16: maximum beats per AXI burst (power of 2, 1..256).
- MAX_OUTSTANDING, 4: maximum AW bursts issued but not yet answered on B (power of 2, 1..16).

Ports:
- aclk  in  1  clock; all logic is on the rising edge.
- areset_n  in  1  asynchronous active-low reset.
- wmst_req  in  1  one-cycle transfer start pulse.
- wmst_xfer_addr  in  64  start byte address; 16-byte aligned.
- wmst_xfer_size  in  64  byte count; multiple of 16.
- wmst_busy  out  1  transfer in progress.
- wmst_done  out  1  one-cycle pulse when the transfer completes.
- wmst_error  out  1  valid together with wmst_done; 1 if any BRESP != OKAY.
- axis_slv_tvalid  in  1  stream data valid.
- axis_slv_tready  out  1  stream ready.
- axis_slv_tdata  in  128  stream data.
- m_axi_awvalid  out  1  write address valid.
- m_axi_awready  in  1  write address ready.
- m_axi_awaddr  out  64  burst start address.
- m_axi_awlen  out  8  beats minus 1.
- m_axi_awsize  out  3  constant 3'b100.
- m_axi_awburst  out  2  constant 2'b01 (INCR).
- m_axi_wvalid  out  1  write data valid.
- m_axi_wready  in  1  write data ready.
- m_axi_wdata  out  128  write data.
- m_axi_wstrb  out  16  constant all ones.
- m_axi_wlast  out  1  last beat of burst.
- m_axi_bvalid  in  1  write response valid.
- m_axi_bready  out  1  write response ready.
- m_axi_bresp  in  2  write response.

Behaviour:
- Reset: all outputs 0 except the constants awsize/awburst/wstrb. State IDLE; counters and the internal length FIFO cleared.
- Reset mid-transfer: everything is abandoned immediately and no done pulse is issued.

State machine:
- IDLE -> RUN on wmst_req. On that edge: latch addr; total_beats = size[63:4]; outstanding = 0; error flag cleared.
- size == 0: IDLE -> DONE directly; no AXI traffic is generated.
- RUN -> DONE when all beats are accepted on W, all bursts are issued, and outstanding == 0.
- DONE -> IDLE after one cycle. In the DONE cycle, wmst_done = 1 and wmst_error shows the error flag.
- wmst_busy = 1 in RUN and DONE.
- wmst_req while not IDLE is ignored.

AW channel:
- Burst length len = min(remaining_aw_beats, MAX_BURST_LEN, 256 - addr[11:4]). A burst never crosses a 4KB boundary.
- awvalid is asserted when remaining_aw_beats > 0, outstanding < MAX_OUTSTANDING, and the length FIFO is not full.
- awaddr/awlen are held stable until awready.
- On the AW handshake: addr += len*16; remaining_aw_beats -= len; outstanding += 1; len is pushed into the length FIFO (depth MAX_OUTSTANDING).

W channel:
- Bursts are sent strictly in AW order. The head of the length FIFO gives the current burst's beat count.
- W never leads AW: with the length FIFO empty, wvalid = 0 and tready = 0.
- Pass-through with no data register: wvalid = tvalid && fifo_nonempty; tready = wready && fifo_nonempty; wdata = tdata.
- On each W handshake the beat counter increments. wlast = 1 when beat == head_len - 1.
- On the wlast handshake the FIFO is popped and the beat counter reset.

B channel:
- bready = 1 in RUN.
- On a B handshake: outstanding -= 1; if bresp != 2'b00, the error flag is set (sticky until the next start).
- If an AW and a B handshake occur in the same cycle, outstanding is unchanged.
- A B handshake with outstanding == 0 is a protocol violation; an assertion flags it in simulation.

Widths:
- Beat counters are 60 bits.
- The address adder is 64 bits and wraps modulo 2^64; no error is raised on wrap.

Test Plan:
- addr 0x1000, size 0x40, all readies high -> one AW with awaddr 0x1000, awlen 3; 4 W beats with wlast on the 4th; done pulse one cycle after B is accepted; error = 0.
- addr 0x0, size 0x1000 -> 16 bursts with awlen 15 at awaddr 0x000, 0x100 … 0xF00; 256 W beats matching stream order; single done pulse.
- addr 0x0FE0, size 0x80 -> AW1 at 0xFE0 with awlen 1; AW2 at 0x1000 with awlen 5; wlast on beats 2 and 8.
- bvalid held low, size 0x1000 -> exactly 4 AW handshakes, then awvalid stays 0. Releasing one B allows exactly one more AW.
- Second burst answered with bresp 2'b10 -> transfer still completes all beats; wmst_done = 1 with wmst_error = 1. The next transfer with OKAY responses reports error = 0.
- areset_n pulsed low mid-transfer -> all outputs reset that cycle, no done pulse. Also: size 0 -> done with no AXI activity; a wmst_req during busy is ignored.
